// File: rtl/clkdiv_pkg.sv
// Shared constants, types and helpers for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int unsigned CW_DEFAULT      = 32;
  localparam int unsigned CLK_HZ          = 50_000_000;
  localparam int unsigned DEFAULT_DIV_1HZ = 25_000_000;

  typedef logic [CW_DEFAULT-1:0] div_t;

  // Half-period in cin cycles for a requested cout frequency.
  function automatic int unsigned hz_to_div(input int unsigned freq);
    return CLK_HZ / (2 * freq);
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: divisor register, counter, cout and tick.
// Optional CLKDIV_SYNC_EN adds a phase-align input.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned    CW          = CW_DEFAULT,
  parameter logic [CW-1:0]  DEFAULT_DIV = CW'(DEFAULT_DIV_1HZ)
) (
  input  logic          cin,
  input  logic          reset,
  input  logic          en,
  input  logic          load,
  input  logic [CW-1:0] load_val,
`ifdef CLKDIV_SYNC_EN
  input  logic          sync,
`endif
  output logic          cout,
  output logic          tick
);

  logic [CW-1:0] div_r;
  logic [CW-1:0] count;
  logic [CW-1:0] eff_div;
  logic          term;

  // >= compare: shrinking the divisor mid-count ends the period at once.
  always_comb begin
    eff_div = (div_r == '0) ? CW'(1) : div_r;
    term    = (count >= (eff_div - CW'(1)));
  end

  always_ff @(posedge cin) begin
    if (reset) begin
      div_r <= DEFAULT_DIV;
      count <= '0;
      cout  <= 1'b0;
      tick  <= 1'b0;
    end else begin
      if (load) div_r <= load_val;
`ifdef CLKDIV_SYNC_EN
      if (sync) begin
        count <= '0;
        cout  <= 1'b0;
        tick  <= 1'b0;
      end else
`endif
      if (load) begin
        count <= '0;
        tick  <= 1'b0;
      end else if (!en) begin
        tick  <= 1'b0;
      end else if (term) begin
        count <= '0;
        cout  <= ~cout;
        tick  <= 1'b1;
      end else begin
        count <= count + CW'(1);
        tick  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_clock_divider.sv
// NCH independent runtime-programmable dividers sharing one load port.
// Optional CLKDIV_SYNC_EN adds a global sync input.
module multi_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int unsigned   NCH         = 4,
  parameter int unsigned   CW          = CW_DEFAULT,
  parameter logic [CW-1:0] DEFAULT_DIV = CW'(DEFAULT_DIV_1HZ),
  localparam int unsigned  CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           cin,
  input  logic           reset,
  input  logic [NCH-1:0] en,
  input  logic           ld,
  input  logic [CHW-1:0] ld_ch,
  input  logic [CW-1:0]  ld_div,
`ifdef CLKDIV_SYNC_EN
  input  logic           sync,
`endif
  output logic           ld_ack,
  output logic           ld_err,
  output logic [NCH-1:0] cout,
  output logic [NCH-1:0] tick
);

  logic           ch_ok;
  logic           ld_ok;
  logic [NCH-1:0] hit;

  always_comb begin
    ch_ok = (32'(ld_ch) < NCH);
    ld_ok = ld && ch_ok;
  end

  always_ff @(posedge cin) begin
    if (reset) begin
      ld_ack <= 1'b0;
      ld_err <= 1'b0;
    end else begin
      ld_ack <= ld_ok;
      ld_err <= ld && !ch_ok;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign hit[i] = ld_ok && (32'(ld_ch) == i);

    clkdiv_channel #(
      .CW          (CW),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .cin      (cin),
      .reset    (reset),
      .en       (en[i]),
      .load     (hit[i]),
      .load_val (ld_div),
`ifdef CLKDIV_SYNC_EN
      .sync     (sync),
`endif
      .cout     (cout[i]),
      .tick     (tick[i])
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed self-checking bench for multi_clock_divider (NCH=3, CW=8, div 4).
`timescale 1ns/1ps
module tb_multi_clock_divider;

  logic       cin = 1'b0;
  logic       reset;
  logic [2:0] en;
  logic       ld;
  logic [1:0] ld_ch;
  logic [7:0] ld_div;
  logic       ld_ack;
  logic       ld_err;
  logic [2:0] cout;
  logic [2:0] tick;
`ifdef CLKDIV_SYNC_EN
  logic       sync = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int n;

  multi_clock_divider #(
    .NCH         (3),
    .CW          (8),
    .DEFAULT_DIV (8'd4)
  ) dut (
    .cin    (cin),
    .reset  (reset),
    .en     (en),
    .ld     (ld),
    .ld_ch  (ld_ch),
    .ld_div (ld_div),
`ifdef CLKDIV_SYNC_EN
    .sync   (sync),
`endif
    .ld_ack (ld_ack),
    .ld_err (ld_err),
    .cout   (cout),
    .tick   (tick)
  );

  always #5 cin = ~cin;

  task automatic cyc();
    @(posedge cin);
    #1;
  endtask

  task automatic chk3(input string tag, input logic [2:0] got,
                      input logic [2:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chkn(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ld    = 1'b0;
    en    = 3'b111;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    en     = 3'b000;
    ld     = 1'b0;
    ld_ch  = 2'd0;
    ld_div = 8'd0;
    cyc();
    cyc();
    chk3("rst_cout", cout, 3'b000);
    chk3("rst_tick", tick, 3'b000);
    chk1("rst_ack", ld_ack, 1'b0);
    chk1("rst_err", ld_err, 1'b0);

    // default divisor 4
    reset = 1'b0;
    en    = 3'b111;
    repeat (3) cyc();
    chk3("def_e3_tick", tick, 3'b000);
    chk3("def_e3_cout", cout, 3'b000);
    cyc();
    chk3("def_e4_tick", tick, 3'b111);
    chk3("def_e4_cout", cout, 3'b111);
    cyc();
    chk3("def_e5_tick", tick, 3'b000);
    repeat (3) cyc();
    chk3("def_e8_tick", tick, 3'b111);
    chk3("def_e8_cout", cout, 3'b000);

    // load ch2 with 3
    ld = 1'b1; ld_ch = 2'd2; ld_div = 8'd3;
    cyc();
    chk1("ld_ack", ld_ack, 1'b1);
    chk3("ld_e9_tick", tick, 3'b000);
    chk3("ld_e9_cout", cout, 3'b000);
    ld = 1'b0;
    cyc();
    chk1("ld_ack_drop", ld_ack, 1'b0);
    repeat (2) cyc();
    chk3("ld_e12_tick", tick, 3'b111);
    chk3("ld_e12_cout", cout, 3'b111);
    repeat (3) cyc();
    chk3("ld_e15_tick", tick, 3'b100);
    chk3("ld_e15_cout", cout, 3'b011);
    cyc();
    chk3("ld_e16_tick", tick, 3'b011);
    chk3("ld_e16_cout", cout, 3'b000);

    // divisors 0 and 1, ld held two cycles
    do_reset();
    ld = 1'b1; ld_ch = 2'd0; ld_div = 8'd0;
    cyc();
    chk1("d01_ack1", ld_ack, 1'b1);
    ld_ch = 2'd1; ld_div = 8'd1;
    cyc();
    chk1("d01_ack2", ld_ack, 1'b1);
    chk3("d01_e2_tick", tick, 3'b001);
    chk3("d01_e2_cout", cout, 3'b001);
    ld = 1'b0;
    cyc();
    chk3("d01_e3_tick", tick, 3'b011);
    chk3("d01_e3_cout", cout, 3'b010);
    cyc();
    chk3("d01_e4_tick", tick, 3'b111);
    chk3("d01_e4_cout", cout, 3'b101);
    cyc();
    chk3("d01_e5_tick", tick, 3'b011);
    chk3("d01_e5_cout", cout, 3'b110);

    // max divisor 255 on ch2, no wrap
    do_reset();
    ld = 1'b1; ld_ch = 2'd2; ld_div = 8'd255;
    cyc();
    ld = 1'b0;
    n = 0;
    while (!tick[2] && n < 300) begin
      cyc();
      n++;
    end
    chkn("max_first", n, 255);
    chk1("max_cout1", cout[2], 1'b1);
    n = 0;
    cyc();
    n++;
    while (!tick[2] && n < 300) begin
      cyc();
      n++;
    end
    chkn("max_period", n, 255);
    chk1("max_cout2", cout[2], 1'b0);

    // load on terminal count of ch0
    do_reset();
    repeat (3) cyc();
    ld = 1'b1; ld_ch = 2'd0; ld_div = 8'd4;
    cyc();
    chk3("lt_e4_tick", tick, 3'b110);
    chk3("lt_e4_cout", cout, 3'b110);
    chk1("lt_ack", ld_ack, 1'b1);
    ld = 1'b0;
    repeat (3) cyc();
    chk3("lt_e7_tick", tick, 3'b000);
    cyc();
    chk3("lt_e8_tick", tick, 3'b111);
    chk3("lt_e8_cout", cout, 3'b001);

    // freeze ch1 for 10 cycles
    do_reset();
    repeat (2) cyc();
    en = 3'b101;
    repeat (2) cyc();
    chk3("en_e4_tick", tick, 3'b101);
    chk3("en_e4_cout", cout, 3'b101);
    repeat (8) cyc();
    chk3("en_e12_tick", tick, 3'b101);
    chk3("en_e12_cout", cout, 3'b101);
    en = 3'b111;
    cyc();
    chk3("en_e13_tick", tick, 3'b000);
    cyc();
    chk3("en_e14_tick", tick, 3'b010);
    chk3("en_e14_cout", cout, 3'b111);

    // out-of-range load
    ld = 1'b1; ld_ch = 2'd3; ld_div = 8'd7;
    cyc();
    chk1("err_err", ld_err, 1'b1);
    chk1("err_ack", ld_ack, 1'b0);
    ld = 1'b0;
    cyc();
    chk1("err_drop", ld_err, 1'b0);
    chk3("err_e16_tick", tick, 3'b101);
    chk3("err_e16_cout", cout, 3'b010);
    repeat (2) cyc();
    chk3("err_e18_tick", tick, 3'b010);
    chk3("err_e18_cout", cout, 3'b000);

    // reset mid-count with a coincident load
    reset = 1'b1; ld = 1'b1; ld_ch = 2'd0; ld_div = 8'd9;
    cyc();
    chk3("rl_cout", cout, 3'b000);
    chk3("rl_tick", tick, 3'b000);
    chk1("rl_ack", ld_ack, 1'b0);
    chk1("rl_err", ld_err, 1'b0);
    reset = 1'b0; ld = 1'b0;
    repeat (3) cyc();
    chk3("rl_e3_tick", tick, 3'b000);
    cyc();
    chk3("rl_e4_tick", tick, 3'b111);
    chk3("rl_e4_cout", cout, 3'b111);

`ifdef CLKDIV_SYNC_EN
    // phase-align channels at different phases
    do_reset();
    en = 3'b001;
    repeat (2) cyc();
    en = 3'b111;
    repeat (2) cyc();
    chk3("sy_pre_cout", cout, 3'b001);
    sync = 1'b1;
    cyc();
    sync = 1'b0;
    chk3("sy_cout", cout, 3'b000);
    chk3("sy_tick", tick, 3'b000);
    repeat (3) cyc();
    chk3("sy_e3_tick", tick, 3'b000);
    cyc();
    chk3("sy_e4_tick", tick, 3'b111);
    chk3("sy_e4_cout", cout, 3'b111);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_clock_divider.md
Name: multi_clock_divider

Overview:
- Multi-channel, runtime-programmable clock/tick generator for the 50 MHz DE10-Lite system clock.
- Each channel has its own divider. It produces a square-wave output (cout) and a single-cycle strobe (tick) at every toggle.
- Typical consumers: game-logic update rate, sprite animation rate, display blink.
- Divisors are reloadable at runtime through a load port, with no re-synthesis needed.

Parameters:
- NCH, 4, number of independent divider channels (1..16).
- CW, 32, counter and divisor width in bits.
- DEFAULT_DIV, 32'd25000000, divisor each channel loads at reset. This is the half-period in cin cycles; the default gives 1 Hz on cout.

Ports:
- cin  input  1  system clock (50 MHz); all logic on posedge cin.
- reset  input  1  synchronous, active-high reset.
- en  input  NCH  per-channel count enable.
- ld  input  1  load strobe; 1-cycle or held, sampled each edge.
- ld_ch  input  max(1,$clog2(NCH))  channel index for the load.
- ld_div  input  CW  new divisor (half-period in cin cycles).
- ld_ack  output  1  registered; high 1 cycle after an accepted load.
- ld_err  output  1  registered; high 1 cycle after a load with ld_ch >= NCH.
- cout  output  NCH  per-channel divided clock; toggles once per divisor period.
- tick  output  NCH  per-channel 1-cycle pulse, coincident with each cout toggle.

Behaviour:
- Reset (reset=1 at posedge cin) has highest priority, including mid-count or mid-load:
  - all count=0, cout=0, tick=0, ld_ack=0, ld_err=0;
  - all div_r=DEFAULT_DIV.
- Per channel i, per edge, with reset=0, in priority order:
  1. Load hit (ld=1, ld_ch==i):
     - div_r<=ld_div, count<=0;
     - cout held, tick<=0;
     - a terminal count in the same cycle is discarded (load wins).
  2. en[i]=0: count and cout frozen, tick<=0.
  3. en[i]=1 and count >= eff_div-1 (terminal count):
     - count<=0, cout<=~cout, tick<=1.
  4. en[i]=1 otherwise: count<=count+1, tick<=0.
- Effective divisor: eff_div = (div_r==0) ? 1 : div_r.
  - Divisor 0 or 1 toggles cout every enabled cycle (cin/2) and holds tick high continuously.
- Compare rule: the compare is >=, so a reload to a smaller divisor can never overrun. Counts never exceed 2^CW-1; no wrap-around.
- Period rules:
  - cout period = 2*eff_div cin cycles while enabled;
  - first tick after a load or reset occurs eff_div enabled cycles later.
- Load handshake:
  - valid ld_ch gives ld_ack=1 next cycle;
  - out-of-range ld_ch gives ld_err=1 next cycle, with no state change on any channel;
  - ld held high for k cycles gives k reloads and k acks; each reload re-zeros count.
- Latency: tick and cout are registered and change on the edge at which the terminal count is detected. There is no combinational path from inputs to outputs.
- Channels are fully independent; only the load port is shared.

Optional Feature:
- Macro: CLKDIV_SYNC_EN.
- When defined, adds an input port sync (1 bit):
  - sync=1 at an edge zeros count and forces cout=0 on all channels (div_r kept, tick<=0), phase-aligning every channel;
  - priority is below reset and above load.
  - A load coincident with sync still updates div_r and still asserts ld_ack.
- When undefined, there is no sync port and no related logic; behaviour is exactly as above.

Decomposition:
- Package clkdiv_pkg holds:
  - CW_DEFAULT, DEFAULT_DIV_1HZ, CLK_HZ=50_000_000;
  - helper constant function hz_to_div(freq) = CLK_HZ/(2*freq);
  - typedef div_t = logic [CW-1:0].
- Sub-module clkdiv_channel: one counter, divisor register, cout/tick.
  - Inputs: cin, reset, en, load, load_val (and sync under CLKDIV_SYNC_EN).
- multi_clock_divider generates NCH instances plus the ld_ch decode and the ld_ack/ld_err registers.

Test Plan:
- Reset default: reset 2 cycles, all en=1, DEFAULT_DIV overridden to 4 → tick every 4 cycles, cout period 8, first tick 4 cycles after reset release, cout starts at 0.
- Load: ld=1, ld_ch=2, ld_div=3 → ld_ack=1 next cycle; channel 2 ticks every 3 cycles; other channels undisturbed; cout[2] level unchanged at load.
- Edge divisors: load ld_div=0 and ld_div=1 → tick held high, cout toggles every cycle; ld_div=2^CW-1 takes no wrap (check with CW=8: period 255).
- Load at terminal count: ld hits channel 0 on the cycle count==div_r-1 → no toggle, no tick, count=0, new period starts.
- Enable and error: en[1]=0 for 10 cycles mid-count → cout[1] and count frozen, tick[1]=0, resumes at the same count; ld_ch=NCH gives ld_err=1, ld_ack=0, no state change.
- Reset and sync: reset asserted mid-count with ld=1 → all outputs 0 and div_r=DEFAULT_DIV next cycle. With CLKDIV_SYNC_EN, channels at different phases pulse sync → all cout=0 and count=0, then ticks coincide for equal divisors.
